// File: rtl/div_pkg.sv
// Shared types and constants for the restoring divider.
package div_pkg;

  // FSM state encodings; also exported on pstate for debug.
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StLoad = 2'b01,
    StIter = 2'b10,
    StDone = 2'b11
  } state_e;

  localparam int unsigned DefaultWidth = 8;

  // Iteration counter width for a given operand width.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

  localparam int unsigned DefaultCntWidth = cnt_width(DefaultWidth);

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract, restore on borrow.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic [WIDTH:0]   i_pr,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH:0]   o_pr,
  output logic             o_qbit
);

  logic [WIDTH+1:0] w_sh;
  logic [WIDTH+1:0] w_diff;

  // Partial remainder stays below the divisor, so one guard bit holds the borrow.
  always_comb begin
    w_sh   = {i_pr, i_bit};
    w_diff = w_sh - {2'b00, i_dvs};
    o_qbit = ~w_diff[WIDTH+1];
    o_pr   = o_qbit ? w_diff[WIDTH:0] : w_sh[WIDTH:0];
  end

endmodule

// File: rtl/div_fsm.sv
// Multi-cycle restoring divider, one quotient bit per clock.
// Define DIV_SIGNED_EN for two's-complement operands and results.
module div_fsm
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s,
  input  logic [WIDTH-1:0] ain,
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             done,
  output logic             busy,
  output logic             err,
  output logic [1:0]       pstate
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e r_state, w_state_next;

  logic [WIDTH-1:0] r_a, r_b;        // raw operands latched on the start edge
  logic [WIDTH-1:0] r_dvs;           // divisor magnitude
  logic [WIDTH-1:0] r_q;             // dividend in, quotient out
  logic [WIDTH:0]   r_pr;            // partial remainder
  logic [CntW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_quo, r_rem;
  logic             r_err;

  logic [WIDTH:0]   w_pr_next;
  logic             w_qbit;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  logic [WIDTH-1:0] w_q_fin, w_r_fin;
  logic             w_err_fin;

`ifdef DIV_SIGNED_EN
  logic r_neg_q, r_neg_r, r_ovf;
`endif

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_pr   (r_pr),
    .i_bit  (r_q[WIDTH-1]),
    .i_dvs  (r_dvs),
    .o_pr   (w_pr_next),
    .o_qbit (w_qbit)
  );

  // Operand magnitudes and sign-corrected final results.
  always_comb begin
    w_a_mag   = r_a;
    w_b_mag   = r_b;
    w_q_fin   = {r_q[WIDTH-2:0], w_qbit};
    w_r_fin   = w_pr_next[WIDTH-1:0];
    w_err_fin = 1'b0;
`ifdef DIV_SIGNED_EN
    if (r_a[WIDTH-1]) w_a_mag = -r_a;
    if (r_b[WIDTH-1]) w_b_mag = -r_b;
    if (r_neg_q) w_q_fin = -{r_q[WIDTH-2:0], w_qbit};
    if (r_neg_r) w_r_fin = -w_pr_next[WIDTH-1:0];
    w_err_fin = r_ovf;
`endif
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (s) w_state_next = StLoad;
      StLoad:  w_state_next = (r_b == '0) ? StDone : StIter;
      StIter:  if (r_cnt == LastCnt) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_dvs <= '0;
      r_q   <= '0;
      r_pr  <= '0;
      r_cnt <= '0;
      r_quo <= '0;
      r_rem <= '0;
      r_err <= 1'b0;
`ifdef DIV_SIGNED_EN
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        StIdle: begin
          if (s) begin
            r_a <= ain;
            r_b <= bin;
          end
        end
        StLoad: begin
          r_pr  <= '0;
          r_cnt <= '0;
          r_q   <= w_a_mag;
          r_dvs <= w_b_mag;
`ifdef DIV_SIGNED_EN
          r_neg_q <= r_a[WIDTH-1] ^ r_b[WIDTH-1];
          r_neg_r <= r_a[WIDTH-1];
          r_ovf   <= (r_a == {1'b1, {(WIDTH-1){1'b0}}}) && (&r_b);
`endif
          if (r_b == '0) begin
            r_quo <= '1;
            r_rem <= r_a;
            r_err <= 1'b1;
          end
        end
        StIter: begin
          r_pr  <= w_pr_next;
          r_q   <= {r_q[WIDTH-2:0], w_qbit};
          r_cnt <= r_cnt + CntW'(1);
          if (r_cnt == LastCnt) begin
            r_quo <= w_q_fin;
            r_rem <= w_r_fin;
            r_err <= w_err_fin;
          end
        end
        default: ;
      endcase
    end
  end

  assign quo    = r_quo;
  assign rem    = r_rem;
  assign err    = r_err;
  assign done   = (r_state == StDone);
  assign busy   = (r_state != StIdle);
  assign pstate = r_state;

endmodule

// File: tb/tb_div_fsm.sv
// Self-checking bench for div_fsm (WIDTH = 8): vector table, corner sequences, random vs model.
module tb_div_fsm;

  logic       clk;
  logic       rst;
  logic       s;
  logic [7:0] ain, bin;
  logic [7:0] quo, rem;
  logic       done, busy, err;
  logic [1:0] pstate;

  int n_pass  = 0;
  int n_total = 0;

  div_fsm #(
    .WIDTH (8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .s      (s),
    .ain    (ain),
    .bin    (bin),
    .quo    (quo),
    .rem    (rem),
    .done   (done),
    .busy   (busy),
    .err    (err),
    .pstate (pstate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       e;
    int         lat;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Reference: quotient/remainder straight from integer arithmetic.
  task automatic model(input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] q, output logic [7:0] r, output logic e);
`ifdef DIV_SIGNED_EN
    int sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sb == 0) begin
      q = 8'hFF; r = a; e = 1'b1;
    end else if (sa == -128 && sb == -1) begin
      q = 8'h80; r = 8'h00; e = 1'b1;
    end else begin
      q = 8'(sa / sb); r = 8'(sa % sb); e = 1'b0;
    end
`else
    if (b == 8'd0) begin
      q = 8'hFF; r = a; e = 1'b1;
    end else begin
      q = a / b; r = a % b; e = 1'b0;
    end
`endif
  endtask

  // Start one operation, return results and the edge number on which done was seen.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] q, output logic [7:0] r, output logic e,
                        output int lat, output logic bsy1, output logic [1:0] after);
    @(negedge clk);
    ain = a; bin = b; s = 1'b1;
    @(posedge clk); #1;
    s = 1'b0;
    lat = 1;
    bsy1 = busy;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    q = quo; r = rem; e = err;
    @(posedge clk); #1;
    after = {done, busy};
  endtask

  initial begin
    logic [7:0] q, r, eq, er;
    logic       e, ee, bsy1;
    logic [1:0] after;
    int         lat, edge_n, d1, d2, n_done;
    logic [7:0] q1, r1, q2, r2;

`ifdef DIV_SIGNED_EN
    vecs[0] = '{a: 8'hF9, b: 8'h02, q: 8'hFD, r: 8'hFF, e: 1'b0, lat: 10};
    vecs[1] = '{a: 8'h80, b: 8'hFF, q: 8'h80, r: 8'h00, e: 1'b1, lat: 10};
    vecs[2] = '{a: 8'd7,  b: 8'd0,  q: 8'hFF, r: 8'd7,  e: 1'b1, lat: 2};
    vecs[3] = '{a: 8'd10, b: 8'd3,  q: 8'd3,  r: 8'd1,  e: 1'b0, lat: 10};
    vecs[4] = '{a: 8'd0,  b: 8'd7,  q: 8'd0,  r: 8'd0,  e: 1'b0, lat: 10};
    vecs[5] = '{a: 8'hF9, b: 8'h00, q: 8'hFF, r: 8'hF9, e: 1'b1, lat: 2};
`else
    vecs[0] = '{a: 8'd10,  b: 8'd3,   q: 8'd3,   r: 8'd1,   e: 1'b0, lat: 10};
    vecs[1] = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0,   e: 1'b0, lat: 10};
    vecs[2] = '{a: 8'd0,   b: 8'd7,   q: 8'd0,   r: 8'd0,   e: 1'b0, lat: 10};
    vecs[3] = '{a: 8'd200, b: 8'd201, q: 8'd0,   r: 8'd200, e: 1'b0, lat: 10};
    vecs[4] = '{a: 8'd7,   b: 8'd0,   q: 8'hFF,  r: 8'd7,   e: 1'b1, lat: 2};
    vecs[5] = '{a: 8'd8,   b: 8'd2,   q: 8'd4,   r: 8'd0,   e: 1'b0, lat: 10};
`endif

    rst = 1'b1; s = 1'b0; ain = '0; bin = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset quo", 32'(quo), 0);
    check("reset rem", 32'(rem), 0);
    check("reset done", 32'(done), 0);
    check("reset busy", 32'(busy), 0);
    check("reset err", 32'(err), 0);
    check("reset pstate", 32'(pstate), 0);
    @(negedge clk);
    rst = 1'b0;

    // Vector table.
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, q, r, e, lat, bsy1, after);
      check($sformatf("vec%0d quo", i), 32'(q), 32'(vecs[i].q));
      check($sformatf("vec%0d rem", i), 32'(r), 32'(vecs[i].r));
      check($sformatf("vec%0d err", i), 32'(e), 32'(vecs[i].e));
      check($sformatf("vec%0d done edge", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d busy at edge1", i), 32'(bsy1), 1);
      check($sformatf("vec%0d done/busy after", i), 32'(after), 0);
    end

    // pstate trace for 10 / 3.
    @(negedge clk);
    ain = 8'd10; bin = 8'd3; s = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      int exp_ps;
      @(posedge clk); #1;
      s = 1'b0;
      exp_ps = (k == 1) ? 1 : (k <= 9) ? 2 : (k == 10) ? 3 : 0;
      check($sformatf("pstate after edge %0d", k), 32'(pstate), 32'(exp_ps));
    end

    // Back-to-back with s held high; operands change after the first start edge.
    @(negedge clk);
    ain = 8'd8; bin = 8'd2; s = 1'b1;
    @(posedge clk); #1;
    ain = 8'd15; bin = 8'd5;
    edge_n = 1; d1 = 0; d2 = 0;
    q1 = '0; r1 = '0; q2 = '0; r2 = '0;
    while (edge_n < 40 && d2 == 0) begin
      @(posedge clk); #1;
      edge_n++;
      if (done) begin
        if (d1 == 0) begin
          d1 = edge_n; q1 = quo; r1 = rem;
        end else begin
          d2 = edge_n; q2 = quo; r2 = rem; s = 1'b0;
        end
      end
    end
    s = 1'b0;
    check("b2b first done edge", 32'(d1), 10);
    check("b2b first quo", 32'(q1), 4);
    check("b2b first rem", 32'(r1), 0);
    check("b2b second done edge", 32'(d2), 21);
    check("b2b second quo", 32'(q2), 3);
    check("b2b second rem", 32'(r2), 0);
    repeat (3) @(posedge clk);

    // Load non-zero outputs, then reset mid-operation.
    run_op(8'd7, 8'd0, q, r, e, lat, bsy1, after);
    @(negedge clk);
    ain = 8'd100; bin = 8'd7; s = 1'b1;
    @(posedge clk); #1;
    s = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst quo", 32'(quo), 0);
    check("midrst rem", 32'(rem), 0);
    check("midrst err", 32'(err), 0);
    check("midrst done", 32'(done), 0);
    check("midrst busy", 32'(busy), 0);
    check("midrst pstate", 32'(pstate), 0);
    rst = 1'b0;
    n_done = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    check("midrst no done", 32'(n_done), 0);
    run_op(8'd9, 8'd4, q, r, e, lat, bsy1, after);
    check("post-reset quo", 32'(q), 2);
    check("post-reset rem", 32'(r), 1);
    check("post-reset err", 32'(e), 0);

    // Random operations against the arithmetic model.
    for (int i = 0; i < 150; i++) begin
      logic [7:0] a, b;
      a = 8'($urandom_range(0, 255));
      b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 15) == 0) begin
        a = 8'h80; b = 8'hFF;
      end
      model(a, b, eq, er, ee);
      run_op(a, b, q, r, e, lat, bsy1, after);
      check($sformatf("rand %0h/%0h quo", a, b), 32'(q), 32'(eq));
      check($sformatf("rand %0h/%0h rem", a, b), 32'(r), 32'(er));
      check($sformatf("rand %0h/%0h err", a, b), 32'(e), 32'(ee));
      check($sformatf("rand %0h/%0h done edge", a, b), 32'(lat), (b == 8'd0) ? 2 : 10);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/div_fsm.md
# div_fsm

Sequential multi-cycle divider that computes quotient and remainder of two operands using restoring division, one quotient bit per clock. It is the inverse-operation companion to the team's FSM multiplier and sits beside it in the 8-bit ALU datapath. It uses the same start-strobe style (`s`), so the ALU sequencer can issue either operation identically. It reports completion with a one-cycle `done` pulse and flags divide-by-zero.

## Interface
- `WIDTH`, default 8: operand, quotient and remainder width; legal range 2–32.
- `clk`  in  1  clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset, sampled on `clk`.
- `s`  in  1  start; sampled only in IDLE.
- `ain`  in  WIDTH  dividend; captured on the start edge.
- `bin`  in  WIDTH  divisor; captured on the start edge.
- `quo`  out  WIDTH  quotient; registered, held until the next operation completes.
- `rem`  out  WIDTH  remainder; registered, held likewise.
- `done`  out  1  one-cycle pulse; `quo`/`rem`/`err` are valid while it is high and afterward.
- `busy`  out  1  high in LOAD, ITER and DONE.
- `err`  out  1  divide-by-zero (and signed overflow under `DIV_SIGNED_EN`); updated with `done`.
- `pstate`  out  2  current state encoding, for debug monitoring.

## Operation
- **States:**
  - IDLE = 00, LOAD = 01, ITER = 10, DONE = 11.
- **Transitions:**
  - IDLE → LOAD when `s` = 1. `ain` and `bin` are latched on that edge.
  - LOAD → DONE if the latched divisor is 0.
  - LOAD → ITER otherwise. LOAD clears the partial remainder (WIDTH+1 bits) and the bit counter, and loads the dividend into the quotient shift register.
  - In ITER, each cycle:
    - shift {partial remainder, dividend MSB} left by one;
    - trial-subtract the divisor;
    - if the result is non-negative, keep it and shift in quotient bit 1;
    - otherwise restore and shift in 0.
  - After WIDTH iterations, ITER → DONE.
  - DONE → IDLE unconditionally. `done` = 1 for this single cycle.
- **Divide-by-zero:** `quo` = all ones, `rem` = dividend, `err` = 1.
- **Normal result:** `err` = 0.
- **`s` while busy:** ignored; it is not queued.
- **`s` held high through DONE:** a new operation starts on the edge after returning to IDLE, so back-to-back operations have one IDLE cycle between them.
- **`ain`/`bin` changes after the start edge:** no effect on the operation in flight.
- **Reset mid-operation:** the operation is aborted. State returns to IDLE, all outputs return to reset values, and no `done` is produced.
- **Reset values:** `quo` = 0, `rem` = 0, `done` = 0, `busy` = 0, `err` = 0, `pstate` = 00.

## Timing
- Edge 1 is the edge that samples `s` = 1 in IDLE.
- Normal operation: `done` is high after edge WIDTH+2 (edge 10 for WIDTH = 8) for exactly one cycle.
- Divide-by-zero: `done` is high after edge 2.
- Issue interval: one operation per WIDTH+3 cycles minimum.
- `busy` rises after edge 1 and falls after the edge that leaves DONE.
- No combinational path from any input to any output.

## Configuration
- **`DIV_SIGNED_EN` undefined:** operands and results are unsigned.
- **`DIV_SIGNED_EN` defined:** operands and results are two's complement.
  - LOAD takes operand magnitudes and records both signs.
  - Division truncates toward zero; the remainder takes the sign of the dividend.
  - Sign correction is applied on the ITER → DONE transition, so latency is unchanged.
  - Most-negative ÷ −1: `quo` = most-negative value, `rem` = 0, `err` = 1.
  - Divide-by-zero: `quo` = all ones, `rem` = dividend as signed, `err` = 1.

## Structure
- Package `div_pkg` holds:
  - the state enum and its 2-bit encodings;
  - the default WIDTH constant;
  - the localparam for the counter width, $clog2(WIDTH)+1.
- Sub-module `div_step`: combinational single restoring iteration.
  - Inputs: partial remainder, incoming dividend bit, divisor.
  - Outputs: next partial remainder, quotient bit.
- `div_fsm` holds the FSM, counter, operand/shift registers, sign handling and output registers.

## Test plan
All scenarios use WIDTH = 8; edges are counted from the start edge as edge 1.
- **10 ÷ 3:** `ain` = 10, `bin` = 3, `s` pulsed → `quo` = 3, `rem` = 1, `err` = 0; `done` high after edge 10 for one cycle; `pstate` sequence 00→01→10(×8)→11→00.
- **Back-to-back, `s` held high:** 8 ÷ 2 then 15 ÷ 5 → (4, 0), then (3, 0). The two `done` pulses are 11 cycles apart; `ain`/`bin` changed mid-operation do not corrupt the first result.
- **Boundary values:**
  - 255 ÷ 1 → (255, 0).
  - 0 ÷ 7 → (0, 0).
  - 200 ÷ 201 → (0, 200).
- **Divide-by-zero:** 7 ÷ 0 → `quo` = 8'hFF, `rem` = 7, `err` = 1; `done` after edge 2.
- **Reset mid-operation:** `rst` = 1 at edge 5 → all outputs 0, `pstate` = 00, no `done`. A new 9 ÷ 4 after reset → (2, 1).
- **Signed (`DIV_SIGNED_EN` defined):**
  - −7 ÷ 2 → `quo` = 8'hFD, `rem` = 8'hFF.
  - −128 ÷ −1 → `quo` = 8'h80, `rem` = 0, `err` = 1.
